// File: rtl/semaphore_controller_if.sv
// Lamp/request bundle between the traffic-light controller and its surroundings.
// The master drives the tick, night mode and requests; the slave drives the lamps.
interface semaphore_controller_if #(
    parameter int unsigned NUM_WAYS = 2
);
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                clk_seconds;
    logic                night_mode;
    logic [NUM_WAYS-1:0] ped_req;
    logic [NUM_WAYS-1:0] green;
    logic [NUM_WAYS-1:0] yellow;
    logic [NUM_WAYS-1:0] red;
    logic [WAY_W-1:0]    active_way;
    logic [NUM_WAYS-1:0] ped_ack;

    modport master (
        output clk_seconds, night_mode, ped_req,
        input  green, yellow, red, active_way, ped_ack
    );

    modport slave (
        input  clk_seconds, night_mode, ped_req,
        output green, yellow, red, active_way, ped_ack
    );
endinterface

// File: rtl/semaphore_controller.sv
// N-way traffic-light controller: green -> yellow -> all-red per approach, paced by a
// seconds tick, with pedestrian early-green termination and a flashing-yellow night mode.
module semaphore_controller #(
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned GREEN_SECS     = 30,
    parameter int unsigned YELLOW_SECS    = 3,
    parameter int unsigned ALL_RED_SECS   = 1,
    parameter int unsigned MIN_GREEN_SECS = 10,
    parameter int unsigned CNT_W          = 8
) (
    input logic                   clk,
    input logic                   rst,
    semaphore_controller_if.slave bus_io
);
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        StAllRed,
        StGreen,
        StYellow,
        StFlashOn,
        StFlashOff
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [NUM_WAYS-1:0] pend_q, pend_d;
    logic [NUM_WAYS-1:0] ack_q, ack_d;
    logic [NUM_WAYS-1:0] green_q, green_d;
    logic [NUM_WAYS-1:0] yellow_q, yellow_d;
    logic [NUM_WAYS-1:0] red_q, red_d;

    logic [NUM_WAYS-1:0] way_mask;
    logic [NUM_WAYS-1:0] next_mask;
    logic [NUM_WAYS-1:0] pend_set;
    logic                others_waiting;

    always_comb begin
        way_mask       = NUM_WAYS'(1) << way_q;
        // A request from the way that already holds green is dropped, not queued.
        pend_set       = pend_q | (bus_io.ped_req & ((state_q == StGreen) ? ~way_mask : '1));
        others_waiting = |(pend_q & ~way_mask);

        state_d = state_q;
        cnt_d   = cnt_q;
        way_d   = way_q;
        pend_d  = pend_set;
        ack_d   = '0;

        if (bus_io.clk_seconds) begin
            cnt_d = cnt_q + 1'b1;
            if (bus_io.night_mode) begin
                cnt_d   = '0;
                state_d = (state_q == StFlashOn) ? StFlashOff : StFlashOn;
            end else begin
                unique case (state_q)
                    StAllRed: begin
                        if (cnt_q == CNT_W'(ALL_RED_SECS - 1)) begin
                            state_d = StGreen;
                            cnt_d   = '0;
                            ack_d   = pend_set & way_mask;
                            pend_d  = pend_set & ~way_mask;
                        end
                    end
                    StGreen: begin
                        if ((cnt_q == CNT_W'(GREEN_SECS - 1)) ||
                            (others_waiting && (cnt_q >= CNT_W'(MIN_GREEN_SECS - 1)))) begin
                            state_d = StYellow;
                            cnt_d   = '0;
                        end
                    end
                    StYellow: begin
                        if (cnt_q == CNT_W'(YELLOW_SECS - 1)) begin
                            state_d = StAllRed;
                            cnt_d   = '0;
                            way_d   = (way_q == WAY_W'(NUM_WAYS - 1)) ? '0 : way_q + 1'b1;
                        end
                    end
                    StFlashOn, StFlashOff: begin
                        state_d = StAllRed;
                        cnt_d   = '0;
                        way_d   = '0;
                    end
                    default: begin
                        state_d = StAllRed;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Lamps are decoded from the next state so they register on the transition edge.
        next_mask = NUM_WAYS'(1) << way_d;
        green_d   = '0;
        yellow_d  = '0;
        red_d     = '0;
        unique case (state_d)
            StAllRed:   red_d = '1;
            StGreen: begin
                green_d = next_mask;
                red_d   = ~next_mask;
            end
            StYellow: begin
                yellow_d = next_mask;
                red_d    = ~next_mask;
            end
            StFlashOn:  yellow_d = '1;
            StFlashOff: red_d = '0;
            default:    red_d = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StAllRed;
            cnt_q    <= '0;
            way_q    <= '0;
            pend_q   <= '0;
            ack_q    <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            way_q    <= way_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    assign bus_io.green      = green_q;
    assign bus_io.yellow     = yellow_q;
    assign bus_io.red        = red_q;
    assign bus_io.active_way = way_q;
    assign bus_io.ped_ack    = ack_q;
endmodule

// File: tb/tb_semaphore_controller.sv
// Bench for semaphore_controller: 2-way and 3-way instances share stimulus and are checked
// every cycle against a countdown-style phase model, plus directed literal checkpoints.
module tb_semaphore_controller;
    localparam int GS = 5;
    localparam int YS = 2;
    localparam int AS = 1;
    localparam int MS = 2;

    localparam int PhAllRed   = 0;
    localparam int PhGreen    = 1;
    localparam int PhYellow   = 2;
    localparam int PhFlashOn  = 3;
    localparam int PhFlashOff = 4;

    typedef struct {
        int       phase;
        int       rem;
        int       way;
        logic [2:0] pend;
        logic [2:0] ack;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs = 1'b0;
    logic       night = 1'b0;
    logic [2:0] req = 3'b000;

    int n_checks = 0;
    int n_err    = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    model_t m2, m3;

    always #5 clk = ~clk;

    semaphore_controller_if #(.NUM_WAYS(2)) if2 ();
    semaphore_controller_if #(.NUM_WAYS(3)) if3 ();

    assign if2.clk_seconds = cs;
    assign if2.night_mode  = night;
    assign if2.ped_req     = req[1:0];
    assign if3.clk_seconds = cs;
    assign if3.night_mode  = night;
    assign if3.ped_req     = req;

    semaphore_controller #(
        .NUM_WAYS(2), .GREEN_SECS(GS), .YELLOW_SECS(YS), .ALL_RED_SECS(AS),
        .MIN_GREEN_SECS(MS), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .bus_io(if2)
    );

    semaphore_controller #(
        .NUM_WAYS(3), .GREEN_SECS(GS), .YELLOW_SECS(YS), .ALL_RED_SECS(AS),
        .MIN_GREEN_SECS(MS), .CNT_W(4)
    ) dut3 (
        .clk(clk), .rst(rst), .bus_io(if3)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic model_t reset_model();
        model_t r;
        r.phase = PhAllRed;
        r.rem   = AS;
        r.way   = 0;
        r.pend  = 3'b000;
        r.ack   = 3'b000;
        return r;
    endfunction

    // One clock of behaviour: rem counts ticks still to spend in the current phase.
    function automatic model_t step(input model_t s, input int n, input logic tick,
                                    input logic nt, input logic [2:0] rq);
        model_t     r;
        logic [2:0] allm, own;
        logic       done;
        r     = s;
        allm  = 3'((1 << n) - 1);
        own   = 3'(1 << s.way);
        r.ack = 3'b000;
        r.pend = s.pend | (rq & allm & ((s.phase == PhGreen) ? ~own : 3'b111));
        if (tick) begin
            if (nt) begin
                r.phase = (s.phase == PhFlashOn) ? PhFlashOff : PhFlashOn;
            end else if (s.phase == PhFlashOn || s.phase == PhFlashOff) begin
                r.phase = PhAllRed;
                r.rem   = AS;
                r.way   = 0;
            end else begin
                done = (s.rem == 1);
                if (s.phase == PhGreen && (s.pend & ~own) != 3'b000 && (GS - s.rem) >= MS - 1)
                    done = 1'b1;
                if (!done) begin
                    r.rem = s.rem - 1;
                end else if (s.phase == PhAllRed) begin
                    r.phase = PhGreen;
                    r.rem   = GS;
                    r.ack   = r.pend & own;
                    r.pend  = r.pend & ~own;
                end else if (s.phase == PhGreen) begin
                    r.phase = PhYellow;
                    r.rem   = YS;
                end else begin
                    r.phase = PhAllRed;
                    r.rem   = AS;
                    r.way   = (s.way + 1) % n;
                end
            end
        end
        return r;
    endfunction

    function automatic void exp_lamps(input model_t s, input int n,
                                      output logic [2:0] g, output logic [2:0] y,
                                      output logic [2:0] r);
        logic [2:0] allm, own;
        allm = 3'((1 << n) - 1);
        own  = 3'(1 << s.way);
        g = 3'b000;
        y = 3'b000;
        r = 3'b000;
        case (s.phase)
            PhAllRed:  r = allm;
            PhGreen:   begin g = own; r = allm & ~own; end
            PhYellow:  begin y = own; r = allm & ~own; end
            PhFlashOn: y = allm;
            default:   ;
        endcase
    endfunction

    task automatic check_inst(input string tag, input model_t s, input int n,
                              input logic [2:0] g, input logic [2:0] y, input logic [2:0] r,
                              input int way, input logic [2:0] ack);
        logic [2:0] eg, ey, er;
        int         lit, greens;
        exp_lamps(s, n, eg, ey, er);
        check({tag, " green"}, int'(g), int'(eg));
        check({tag, " yellow"}, int'(y), int'(ey));
        check({tag, " red"}, int'(r), int'(er));
        check({tag, " active_way"}, way, s.way);
        check({tag, " ped_ack"}, int'(ack), int'(s.ack));
        if (s.phase != PhFlashOn && s.phase != PhFlashOff) begin
            greens = 0;
            for (int i = 0; i < n; i++) begin
                lit = int'(g[i]) + int'(y[i]) + int'(r[i]);
                greens += int'(g[i]);
                check({tag, " one lamp per way"}, lit, 1);
            end
            check({tag, " single green"}, int'(greens <= 1), 1);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m2 = reset_model();
            m3 = reset_model();
        end else begin
            m2 = step(m2, 2, cs, night, {1'b0, req[1:0]});
            m3 = step(m3, 3, cs, night, req);
        end
    end

    initial forever begin
        @(negedge clk);
        check_inst("w2", m2, 2, {1'b0, if2.green}, {1'b0, if2.yellow}, {1'b0, if2.red},
                   int'(if2.active_way), {1'b0, if2.ped_ack});
        check_inst("w3", m3, 3, if3.green, if3.yellow, if3.red,
                   int'(if3.active_way), if3.ped_ack);
    end

    initial forever begin
        @(negedge clk);
        if (if2.ped_ack[0]) ack0_cnt++;
        if (if2.ped_ack[1]) ack1_cnt++;
    end

    // One tick every 4 clocks; returns well after the tick edge so outputs are settled.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk); cs = 1'b1;
            @(negedge clk); cs = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_req(input logic [2:0] v);
        @(negedge clk); req = v;
        @(negedge clk); req = 3'b000;
    endtask

    initial begin
        int a0, a1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset red", int'(if2.red), 3);
        check("reset green", int'(if2.green), 0);
        check("reset yellow", int'(if2.yellow), 0);
        check("reset way", int'(if2.active_way), 0);
        check("reset ack", int'(if2.ped_ack), 0);
        rst = 1'b0;

        // Free-running cycle with no requests.
        tick(1);
        check("t1 green0", int'(if2.green), 1);
        check("t1 red0", int'(if2.red), 2);
        tick(4);
        check("t1 green held", int'(if2.green), 1);
        tick(1);
        check("t1 yellow0", int'(if2.yellow), 1);
        tick(2);
        check("t1 allred", int'(if2.red), 3);
        check("t1 way1", int'(if2.active_way), 1);
        tick(1);
        check("t1 green1", int'(if2.green), 2);
        tick(5);
        check("t1 yellow1", int'(if2.yellow), 2);
        tick(3);
        check("t1 green0 again", int'(if2.green), 1);
        check("t4 3way green2", int'(if3.green), 4);
        check("t4 3way way2", int'(if3.active_way), 2);

        // Pedestrian request cuts way 0 green short at minimum green.
        pulse_req(3'b010);
        a1 = ack1_cnt;
        tick(1);
        check("t2 green after 1", int'(if2.green), 1);
        tick(1);
        check("t2 early yellow", int'(if2.yellow), 1);
        tick(2);
        check("t2 way1", int'(if2.active_way), 1);
        tick(1);
        check("t2 green1", int'(if2.green), 2);
        check("t2 ack1 once", ack1_cnt - a1, 1);

        // Night mode mid-green.
        tick(1);
        night = 1'b1;
        tick(1);
        check("t3 flash on y", int'(if2.yellow), 3);
        check("t3 flash on r", int'(if2.red), 0);
        check("t3 flash on g", int'(if2.green), 0);
        tick(1);
        check("t3 flash off", int'({if2.green, if2.yellow, if2.red}), 0);
        tick(1);
        check("t3 flash on again", int'(if2.yellow), 3);
        night = 1'b0;
        tick(1);
        check("t3 exit allred", int'(if2.red), 3);
        check("t3 exit way0", int'(if2.active_way), 0);
        tick(1);
        check("t3 green0", int'(if2.green), 1);

        // No ticks: lamps frozen, own-way request ignored.
        a0 = ack0_cnt;
        repeat (10) @(negedge clk);
        req = 3'b001;
        @(negedge clk);
        req = 3'b000;
        repeat (39) @(negedge clk);
        check("t6 frozen green", int'(if2.green), 1);
        check("t6 no ack0", ack0_cnt - a0, 0);
        tick(4);
        check("t6 no early exit", int'(if2.green), 1);
        tick(1);
        check("t6 yellow0", int'(if2.yellow), 1);

        // Asynchronous reset in yellow wipes the pending request.
        pulse_req(3'b010);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 async red", int'(if2.red), 3);
        check("t5 async yellow", int'(if2.yellow), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("t5 green0", int'(if2.green), 1);
        tick(4);
        check("t5 no early term", int'(if2.green), 1);
        tick(1);
        check("t5 yellow0", int'(if2.yellow), 1);

        // Randomised run against the model.
        repeat (6000) begin
            @(negedge clk);
            cs = !cs && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) night = !night;
            req = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
